spi_slave_ctrl: RTL and testbench

//  SPI slave endpoint (mode 0, MSB first) that answers the 4-word SPI master controller transaction.

---
 rtl/spi_slave_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_spi_slave_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_ctrl.sv
// ============================================================================
// Module      : spi_slave_ctrl
// Description : SPI mode-0 slave endpoint, MSB first. Oversamples SCLK, SS_n
//               and MOSI on clk_in and captures up to four words per frame
//               into rx_reg_1..4. It returns tx_word_1..4 on MISO and reports
//               per-word valid, end-of-frame, fragment and overrun status.
//               Optional build macro: SPI_SLAVE_MISO_TRISTATE_EN releases
//               MISO to high-impedance whenever the slave is not shifting.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_slave_ctrl #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_in,
    input  logic                 n_rst,
    input  logic                 sclk_in,
    input  logic                 ss_n_in,
    input  logic                 mosi_in,
    output logic                 miso_out,
    input  logic [DATA_BITS-1:0] tx_word_1,
    input  logic [DATA_BITS-1:0] tx_word_2,
    input  logic [DATA_BITS-1:0] tx_word_3,
    input  logic [DATA_BITS-1:0] tx_word_4,
    output logic [DATA_BITS-1:0] rx_reg_1_out,
    output logic [DATA_BITS-1:0] rx_reg_2_out,
    output logic [DATA_BITS-1:0] rx_reg_3_out,
    output logic [DATA_BITS-1:0] rx_reg_4_out,
    output logic                 valid_out,
    output logic                 frame_done_out,
    output logic                 busy_out,
    output logic [2:0]           word_cnt_out,
    output logic                 frag_err_out,
    output logic                 overrun_out
);

    localparam int c_BIT_W    = $clog2(DATA_BITS + 1);
    // Cycles after reset during which a low SS_n means "already mid-transfer".
    localparam int c_SETTLE   = SYNC_STAGES + 1;
    localparam int c_SETTLE_W = $clog2(c_SETTLE + 1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ARMED_WAIT = 2'd1,
        ST_SHIFT      = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_hist_q, sclk_hist_d;
    logic                   ss_hist_q, ss_hist_d;
    logic [c_SETTLE_W-1:0]  settle_q, settle_d;
    logic [c_BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [2:0]             word_cnt_q, word_cnt_d;
    logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
    logic [DATA_BITS-1:0]   rx_reg_q [4];
    logic [DATA_BITS-1:0]   rx_reg_d [4];
    logic                   miso_q, miso_d;
    logic                   valid_q, valid_d;
    logic                   frame_done_q, frame_done_d;
    logic                   busy_q, busy_d;
    logic                   frag_err_q, frag_err_d;
    logic                   overrun_q, overrun_d;

    logic                   w_sclk_s, w_ss_s, w_mosi_s;
    logic                   w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;
    logic [DATA_BITS-1:0]   w_rx_word;
    logic [DATA_BITS-1:0]   w_next_tx;

    assign w_sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign w_ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign w_mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~sclk_hist_q;
    assign w_sclk_fall = ~w_sclk_s & sclk_hist_q;
    assign w_ss_rise   = w_ss_s & ~ss_hist_q;
    assign w_ss_fall   = ~w_ss_s & ss_hist_q;
    assign w_rx_word   = {rx_shift_q[DATA_BITS-2:0], w_mosi_s};

    // Response word to load at a word boundary; zeros once all four are sent.
    always_comb begin
        w_next_tx = '0;
        case (word_cnt_q)
            3'd0:    w_next_tx = tx_word_1;
            3'd1:    w_next_tx = tx_word_2;
            3'd2:    w_next_tx = tx_word_3;
            3'd3:    w_next_tx = tx_word_4;
            default: w_next_tx = '0;
        endcase
    end

    // Next-state logic for synchronisers, frame FSM and datapath.
    always_comb begin
        state_d      = state_q;
        sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
        ss_sync_d    = {ss_sync_q[SYNC_STAGES-2:0], ss_n_in};
        mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
        sclk_hist_d  = w_sclk_s;
        ss_hist_d    = w_ss_s;
        settle_d     = (settle_q != '0) ? settle_q - c_SETTLE_W'(1) : settle_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        rx_reg_d     = rx_reg_q;
        miso_d       = miso_q;
        valid_d      = 1'b0;
        frame_done_d = 1'b0;
        frag_err_d   = frag_err_q;
        overrun_d    = overrun_q;

        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if ((settle_q != '0) && !w_ss_s) begin
                    // SS_n was already low when reset ended: never join mid-frame.
                    state_d = ST_ARMED_WAIT;
                end else if ((settle_q == '0) && w_ss_fall) begin
                    state_d    = ST_SHIFT;
                    tx_shift_d = tx_word_1;
                    miso_d     = tx_word_1[DATA_BITS-1];
                    rx_shift_d = '0;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    frag_err_d = 1'b0;
                    overrun_d  = 1'b0;
                end
            end
            ST_ARMED_WAIT: begin
                miso_d = 1'b0;
                if (w_ss_s) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_ss_rise) begin
                    // End of frame has priority over any coincident SCLK edge.
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                    miso_d       = 1'b0;
                    bit_cnt_d    = '0;
                    if (bit_cnt_q != '0) begin
                        frag_err_d = 1'b1;
                    end
                end else if (w_sclk_rise) begin
                    rx_shift_d = w_rx_word;
                    if (bit_cnt_q == c_BIT_W'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        if (word_cnt_q < 3'd4) begin
                            rx_reg_d[word_cnt_q[1:0]] = w_rx_word;
                            valid_d                   = 1'b1;
                            word_cnt_d                = word_cnt_q + 3'd1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + c_BIT_W'(1);
                    end
                end else if (w_sclk_fall) begin
                    if (bit_cnt_q == '0) begin
                        tx_shift_d = w_next_tx;
                        miso_d     = w_next_tx[DATA_BITS-1];
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_BITS-2:0], 1'b0};
                        miso_d     = tx_shift_q[DATA_BITS-2];
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                miso_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            sclk_sync_q  <= '0;
            ss_sync_q    <= '1;
            mosi_sync_q  <= '0;
            sclk_hist_q  <= 1'b0;
            ss_hist_q    <= 1'b1;
            settle_q     <= c_SETTLE_W'(c_SETTLE);
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            rx_shift_q   <= '0;
            tx_shift_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                rx_reg_q[i] <= '0;
            end
            miso_q       <= 1'b0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            frag_err_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sclk_sync_q  <= sclk_sync_d;
            ss_sync_q    <= ss_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            sclk_hist_q  <= sclk_hist_d;
            ss_hist_q    <= ss_hist_d;
            settle_q     <= settle_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            rx_reg_q     <= rx_reg_d;
            miso_q       <= miso_d;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            frag_err_q   <= frag_err_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign miso_out = (state_q == ST_SHIFT) ? miso_q : 1'bz;
`else
    assign miso_out = miso_q;
`endif

    assign rx_reg_1_out   = rx_reg_q[0];
    assign rx_reg_2_out   = rx_reg_q[1];
    assign rx_reg_3_out   = rx_reg_q[2];
    assign rx_reg_4_out   = rx_reg_q[3];
    assign valid_out      = valid_q;
    assign frame_done_out = frame_done_q;
    assign busy_out       = busy_q;
    assign word_cnt_out   = word_cnt_q;
    assign frag_err_out   = frag_err_q;
    assign overrun_out    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_ctrl.sv
// ============================================================================
// Module      : tb_spi_slave_ctrl
// Description : Directed self-checking bench for spi_slave_ctrl acting as a
//               mode-0 SPI master. Optional build macro:
//               SPI_SLAVE_MISO_TRISTATE_EN selects the idle MISO expectation.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_slave_ctrl;

    localparam int HALF = 80;   // SCLK half period in ns (8 clk_in cycles)

    logic       clk_in = 1'b0;
    logic       n_rst = 1'b0;
    logic       sclk_in = 1'b0;
    logic       ss_n_in = 1'b1;
    logic       mosi_in = 1'b0;
    logic       miso_out;
    logic [7:0] tx1 = 8'h11, tx2 = 8'h22, tx3 = 8'h33, tx4 = 8'h44;
    logic [7:0] rx1, rx2, rx3, rx4;
    logic       valid_out, frame_done_out, busy_out, frag_err_out, overrun_out;
    logic [2:0] word_cnt_out;

    int         checks = 0;
    int         failures = 0;
    int         valid_seen = 0;
    int         fd_seen = 0;
    int         v0, f0;
    logic [7:0] m_r = 8'h00;
    logic [7:0] got [5];
    logic       exp_idle_miso;

    spi_slave_ctrl #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk_in        (clk_in),
        .n_rst         (n_rst),
        .sclk_in       (sclk_in),
        .ss_n_in       (ss_n_in),
        .mosi_in       (mosi_in),
        .miso_out      (miso_out),
        .tx_word_1     (tx1),
        .tx_word_2     (tx2),
        .tx_word_3     (tx3),
        .tx_word_4     (tx4),
        .rx_reg_1_out  (rx1),
        .rx_reg_2_out  (rx2),
        .rx_reg_3_out  (rx3),
        .rx_reg_4_out  (rx4),
        .valid_out     (valid_out),
        .frame_done_out(frame_done_out),
        .busy_out      (busy_out),
        .word_cnt_out  (word_cnt_out),
        .frag_err_out  (frag_err_out),
        .overrun_out   (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk_in) begin
        if (valid_out)      valid_seen <= valid_seen + 1;
        if (frame_done_out) fd_seen    <= fd_seen + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Clock bits d[hi] down to d[lo]; MISO is captured into m_r at each rise.
    task automatic spi_bits(input logic [7:0] d, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            mosi_in = d[i];
            #(HALF);
            sclk_in = 1'b1;
            m_r = {m_r[6:0], miso_out};
            #(HALF);
            sclk_in = 1'b0;
        end
    endtask

    task automatic ss_begin();
        ss_n_in = 1'b0;
        #(HALF);
    endtask

    task automatic ss_end();
        #(HALF);
        ss_n_in = 1'b1;
        #(3 * HALF);
    endtask

    initial begin
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
        exp_idle_miso = 1'bz;
`else
        exp_idle_miso = 1'b0;
`endif
        // ---------------- reset state ----------------
        n_rst = 1'b0;
        #100;
        chk("rst_rx1", rx1, 8'h00);
        chk("rst_rx4", rx4, 8'h00);
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_busy", busy_out, 1'b0);
        chk("rst_wcnt", word_cnt_out, 3'd0);
        chk("rst_frag", frag_err_out, 1'b0);
        chk("rst_ovr", overrun_out, 1'b0);
        chk("rst_miso", miso_out, exp_idle_miso);
        n_rst = 1'b1;
        #200;

        // ---------------- scenario 1: full 4-word frame ----------------
        v0 = valid_seen; f0 = fd_seen;
        ss_begin();
        spi_bits(8'hFA, 7, 0); got[0] = m_r;
        chk("s1_busy", busy_out, 1'b1);
        spi_bits(8'hFB, 7, 0); got[1] = m_r;
        spi_bits(8'hFC, 7, 0); got[2] = m_r;
        spi_bits(8'hFD, 7, 0); got[3] = m_r;
        ss_end();
        chk("s1_rx1", rx1, 8'hFA);
        chk("s1_rx2", rx2, 8'hFB);
        chk("s1_rx3", rx3, 8'hFC);
        chk("s1_rx4", rx4, 8'hFD);
        chk("s1_miso1", got[0], 8'h11);
        chk("s1_miso2", got[1], 8'h22);
        chk("s1_miso3", got[2], 8'h33);
        chk("s1_miso4", got[3], 8'h44);
        chk("s1_valids", valid_seen - v0, 4);
        chk("s1_fdone", fd_seen - f0, 1);
        chk("s1_wcnt", word_cnt_out, 3'd4);
        chk("s1_frag", frag_err_out, 1'b0);
        chk("s1_ovr", overrun_out, 1'b0);
        chk("s1_busy_end", busy_out, 1'b0);
        chk("s1_miso_idle", miso_out, exp_idle_miso);

        // ---------------- scenario 2: fragment ----------------
        v0 = valid_seen; f0 = fd_seen;
        ss_begin();
        spi_bits(8'hFA, 7, 0);
        spi_bits(8'h5C, 7, 3);
        ss_end();
        chk("s2_rx1", rx1, 8'hFA);
        chk("s2_rx2", rx2, 8'hFB);
        chk("s2_wcnt", word_cnt_out, 3'd1);
        chk("s2_frag", frag_err_out, 1'b1);
        chk("s2_valids", valid_seen - v0, 1);
        chk("s2_fdone", fd_seen - f0, 1);

        // ---------------- scenario 3: overrun ----------------
        v0 = valid_seen;
        ss_begin();
        spi_bits(8'hA1, 7, 0);
        spi_bits(8'hA2, 7, 0);
        spi_bits(8'hA3, 7, 0);
        spi_bits(8'hA4, 7, 0);
        spi_bits(8'hA5, 7, 0); got[4] = m_r;
        ss_end();
        chk("s3_rx1", rx1, 8'hA1);
        chk("s3_rx4", rx4, 8'hA4);
        chk("s3_ovr", overrun_out, 1'b1);
        chk("s3_frag", frag_err_out, 1'b0);
        chk("s3_valids", valid_seen - v0, 4);
        chk("s3_miso5", got[4], 8'h00);
        chk("s3_wcnt", word_cnt_out, 3'd4);

        // ---------------- scenario 4: reset mid-frame ----------------
        ss_begin();
        spi_bits(8'hB1, 7, 0);
        spi_bits(8'hB2, 7, 5);
        @(negedge clk_in); n_rst = 1'b0;
        @(negedge clk_in); n_rst = 1'b1;
        v0 = valid_seen;
        spi_bits(8'hB3, 7, 0);
        spi_bits(8'hB4, 7, 4);
        #(2 * HALF);
        chk("s4_valids", valid_seen - v0, 0);
        chk("s4_rx1", rx1, 8'h00);
        chk("s4_rx2", rx2, 8'h00);
        chk("s4_wcnt", word_cnt_out, 3'd0);
        chk("s4_armed_busy", busy_out, 1'b1);
        ss_end();
        chk("s4_idle_busy", busy_out, 1'b0);
        v0 = valid_seen;
        ss_begin();
        spi_bits(8'hC1, 7, 0); got[0] = m_r;
        spi_bits(8'hC2, 7, 0); got[1] = m_r;
        spi_bits(8'hC3, 7, 0); got[2] = m_r;
        spi_bits(8'hC4, 7, 0); got[3] = m_r;
        ss_end();
        chk("s4_rx1", rx1, 8'hC1);
        chk("s4_rx4", rx4, 8'hC4);
        chk("s4_miso1", got[0], 8'h11);
        chk("s4_miso4", got[3], 8'h44);
        chk("s4_valids2", valid_seen - v0, 4);

        // ---------------- scenario 5: tx word sampling instant ----------------
        ss_begin();
        spi_bits(8'h01, 7, 4);
        tx2 = 8'h55;
        spi_bits(8'h01, 3, 0);
        spi_bits(8'h02, 7, 0); got[1] = m_r;
        ss_end();
        chk("s5_miso2_early", got[1], 8'h55);
        tx2 = 8'h22;
        ss_begin();
        spi_bits(8'h03, 7, 0);
        spi_bits(8'h04, 7, 4);
        tx2 = 8'h66;
        spi_bits(8'h04, 3, 0); got[1] = m_r;
        ss_end();
        chk("s5_miso2_late", got[1], 8'h22);
        chk("s5_rx2", rx2, 8'h04);
        chk("s5_miso_idle", miso_out, exp_idle_miso);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
